timer_core: RTL and testbench

Parametrised HH:MM:SS timer core. It replaces the single mod-60 stage counter with a three-stage cascade (seconds, minutes, hours) driven by an internal clock prescaler. It counts up (stopwatch) or down (countdown) and has load, pause, clear and an expiry flag. It sits between the board clock and the display/BCD driver.

---
 rtl/timer_pkg.sv | 18 +
 rtl/mod_counter_stage.sv | 41 ++++
 rtl/timer_core.sv | 141 ++++++++++++++
 tb/tb_timer_core.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the HH:MM:SS timer core.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mod_counter_stage.sv
// One modulo-MOD up/down counter digit of the timer cascade.
module mod_counter_stage
    import timer_pkg::*;
#(
    parameter int MOD = 60,
    localparam int W = cnt_w(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] val,
    output logic [W-1:0] nxt,
    output logic         cy
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    always_comb begin
        nxt = val;
        if (clr) begin
            nxt = '0;
        end else if (load) begin
            nxt = (load_val > TOP) ? TOP : load_val;
        end else if (en) begin
            if (dir == MODE_DOWN) nxt = (val == '0) ? TOP : val - 1'b1;
            else nxt = (val == TOP) ? '0 : val + 1'b1;
        end
    end

    assign cy = en && ((dir == MODE_DOWN) ? (val == '0) : (val == TOP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) val <= '0;
        else val <= nxt;
    end

endmodule

// File: rtl/timer_core.sv
// HH:MM:SS up/down timer with prescaler, pause, load and expiry.
// Optional alarm comparator enabled by defining TIMER_CORE_ALARM_EN.
module timer_core
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int SEC_MOD  = 60,
    parameter int MIN_MOD  = 60,
    parameter int HR_MOD   = 24,
    localparam int SEC_W = cnt_w(SEC_MOD),
    localparam int MIN_W = cnt_w(MIN_MOD),
    localparam int HR_W  = cnt_w(HR_MOD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             mode,
    input  logic             load_en,
    input  logic [SEC_W-1:0] load_sec,
    input  logic [MIN_W-1:0] load_min,
    input  logic [HR_W-1:0]  load_hr,
`ifdef TIMER_CORE_ALARM_EN
    input  logic [SEC_W-1:0] alarm_sec,
    input  logic [MIN_W-1:0] alarm_min,
    input  logic [HR_W-1:0]  alarm_hr,
    output logic             alarm,
`endif
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic             running,
    output logic             expired,
    output logic             tick,
    output logic             wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            do_tick, clr, ld;
    logic            s_cy, m_cy, h_cy;
    logic [SEC_W-1:0] s_nxt;
    logic [MIN_W-1:0] m_nxt;
    logic [HR_W-1:0]  h_nxt;
    logic            zero, at_one;

    assign zero   = (sec == '0) && (min == '0) && (hr == '0);
    assign at_one = (sec == SEC_W'(1)) && (min == '0) && (hr == '0);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        do_tick = 1'b0;
        clr     = 1'b0;
        ld      = 1'b0;
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
            clr     = 1'b1;
        end else if (load_en && (state_q == IDLE || state_q == EXPIRED)) begin
            state_d = IDLE;
            ld      = 1'b1;
        end else if (start && state_q == IDLE) begin
            mode_d  = mode;
            presc_d = '0;
            state_d = (mode == MODE_DOWN && zero) ? EXPIRED : RUN;
        end else begin
            unique case (state_q)
                RUN, PAUSED: begin
                    // The resume cycle counts; only cycles with pause high stall.
                    if (pause) begin
                        state_d = PAUSED;
                    end else begin
                        state_d = RUN;
                        if (presc_q == LAST) begin
                            presc_d = '0;
                            do_tick = 1'b1;
                            if (mode_q == MODE_DOWN && at_one) state_d = EXPIRED;
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    mod_counter_stage #(.MOD(SEC_MOD)) u_sec (
        .clk(clk), .reset(reset), .clr(clr), .en(do_tick), .dir(mode_q),
        .load(ld), .load_val(load_sec), .val(sec), .nxt(s_nxt), .cy(s_cy)
    );

    mod_counter_stage #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .reset(reset), .clr(clr), .en(s_cy), .dir(mode_q),
        .load(ld), .load_val(load_min), .val(min), .nxt(m_nxt), .cy(m_cy)
    );

    mod_counter_stage #(.MOD(HR_MOD)) u_hr (
        .clk(clk), .reset(reset), .clr(clr), .en(m_cy), .dir(mode_q),
        .load(ld), .load_val(load_hr), .val(hr), .nxt(h_nxt), .cy(h_cy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_UP;
            presc_q <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            tick    <= do_tick;
            wrap    <= do_tick && (mode_q == MODE_UP) && h_cy;
            running <= (state_d == RUN);
            expired <= (state_d == EXPIRED);
        end
    end

`ifdef TIMER_CORE_ALARM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) alarm <= 1'b0;
        else alarm <= do_tick && (s_nxt == alarm_sec) &&
                      (m_nxt == alarm_min) && (h_nxt == alarm_hr);
    end
`else
    logic unused_nxt;
    assign unused_nxt = ^{s_nxt, m_nxt, h_nxt};
`endif

endmodule

// File: tb/tb_timer_core.sv
// Randomized and directed bench for timer_core against a total-seconds model.
module tb_timer_core;

    localparam int TD  = 4;
    localparam int SM  = 60;
    localparam int MM  = 60;
    localparam int HM  = 24;
    localparam int TOT = SM * MM * HM;
    localparam int S_IDLE = 0, S_RUN = 1, S_PSD = 2, S_EXP = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, pause = 1'b0, clear = 1'b0, mode = 1'b0, load_en = 1'b0;
    logic [5:0] load_sec = '0, load_min = '0;
    logic [4:0] load_hr = '0;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic running, expired, tick, wrap;
`ifdef TIMER_CORE_ALARM_EN
    logic [5:0] alarm_sec = 6'd3, alarm_min = '0;
    logic [4:0] alarm_hr = '0;
    logic alarm;
`endif

    timer_core #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .clear(clear), .mode(mode), .load_en(load_en),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
`ifdef TIMER_CORE_ALARM_EN
        .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
        .alarm(alarm),
`endif
        .sec(sec), .min(min), .hr(hr), .running(running),
        .expired(expired), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int m_st, m_tot, m_cnt, m_md;
    bit e_tick, e_wrap, e_alarm;
    int ticks_seen, wraps_seen, alarms_seen;
    string phase = "reset";

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampv(input int v, input int m);
        return (v >= m) ? m - 1 : v;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_tot = 0; m_cnt = 0; m_md = 0;
        e_tick = 0; e_wrap = 0; e_alarm = 0;
    endtask

    // Expected state after the coming clock edge given the current inputs.
    task automatic model_step();
        e_tick = 0; e_wrap = 0; e_alarm = 0;
        if (clear) begin
            m_st = S_IDLE; m_tot = 0; m_cnt = 0;
        end else if (load_en && (m_st == S_IDLE || m_st == S_EXP)) begin
            m_tot = clampv(int'(load_sec), SM) + SM * clampv(int'(load_min), MM)
                  + SM * MM * clampv(int'(load_hr), HM);
            m_st = S_IDLE;
        end else if (start && m_st == S_IDLE) begin
            m_md = int'(mode); m_cnt = 0;
            m_st = (mode && m_tot == 0) ? S_EXP : S_RUN;
        end else if (m_st == S_RUN || m_st == S_PSD) begin
            if (pause) begin
                m_st = S_PSD;
            end else begin
                m_st = S_RUN;
                m_cnt++;
                if (m_cnt == TD) begin
                    m_cnt = 0;
                    e_tick = 1;
                    if (m_md == 0) begin
                        m_tot = (m_tot + 1) % TOT;
                        e_wrap = (m_tot == 0);
                    end else begin
                        m_tot = m_tot - 1;
                        if (m_tot == 0) m_st = S_EXP;
                    end
                    e_alarm = (m_tot == 3);
                end
            end
        end
    endtask

    task automatic check_outs();
        check({phase, ".sec"}, int'(sec), m_tot % SM);
        check({phase, ".min"}, int'(min), (m_tot / SM) % MM);
        check({phase, ".hr"}, int'(hr), m_tot / (SM * MM));
        check({phase, ".running"}, int'(running), int'(m_st == S_RUN));
        check({phase, ".expired"}, int'(expired), int'(m_st == S_EXP));
        check({phase, ".tick"}, int'(tick), int'(e_tick));
        check({phase, ".wrap"}, int'(wrap), int'(e_wrap));
`ifdef TIMER_CORE_ALARM_EN
        check({phase, ".alarm"}, int'(alarm), int'(e_alarm));
        alarms_seen += int'(alarm);
`endif
        ticks_seen += int'(tick);
        wraps_seen += int'(wrap);
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(input int n, input bit pa = 1'b0);
        start = 0; clear = 0; load_en = 0; pause = pa;
        repeat (n) cyc();
    endtask

    task automatic drive(input bit st, input bit cl, input bit md,
                         input bit le, input int ls, input int lm, input int lh);
        start = st; clear = cl; mode = md; load_en = le; pause = 0;
        load_sec = 6'(ls); load_min = 6'(lm); load_hr = 5'(lh);
        cyc();
    endtask

    initial begin
        model_reset();
        ticks_seen = 0; wraps_seen = 0; alarms_seen = 0;
        @(negedge clk);
        check_outs();
        @(negedge clk);
        reset = 0;

        phase = "up_carry";
        drive(0, 0, 0, 1, 58, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        ticks_seen = 0; wraps_seen = 0;
        idle(8);
        check("up_carry.min_const", int'(min), 1);
        check("up_carry.sec_const", int'(sec), 0);
        check("up_carry.ticks", ticks_seen, 2);
        check("up_carry.wraps", wraps_seen, 0);

        phase = "up_wrap";
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 59, 59, 23);
        drive(1, 0, 0, 0, 0, 0, 0);
        wraps_seen = 0;
        idle(4);
        check("up_wrap.wrap_now", int'(wrap), 1);
        check("up_wrap.hr_const", int'(hr), 0);
        idle(1);
        check("up_wrap.wraps", wraps_seen, 1);

        phase = "down";
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        idle(4);
        check("down.sec_const", int'(sec), 59);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        idle(8);
        check("down.expired_const", int'(expired), 1);
        drive(1, 0, 1, 0, 0, 0, 0);
        check("down.start_ignored", int'(running), 0);

        phase = "pause";
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        ticks_seen = 0;
        idle(2);
        idle(5, 1'b1);
        idle(1);
        check("pause.no_early_tick", ticks_seen, 0);
        idle(1);
        check("pause.tick_at_9", int'(tick), 1);
        idle(3);
        idle(1, 1'b1);
        check("pause.terminal_suppressed", int'(tick), 0);
        idle(1);
        check("pause.resume_tick", int'(sec), 2);

        phase = "areset";
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 17, 3, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        #2 reset = 1;
        #1;
        check("areset.sec", int'(sec), 0);
        check("areset.min", int'(min), 0);
        check("areset.running", int'(running), 0);
        check("areset.any", int'({hr, expired, tick, wrap}), 0);
        model_reset();
        @(negedge clk);
        check_outs();
        reset = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        check("areset.idle_start", int'(running), 1);

`ifdef TIMER_CORE_ALARM_EN
        phase = "alarm";
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        alarms_seen = 0;
        idle(16);
        check("alarm.count", alarms_seen, 1);
`endif

        phase = "rand";
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            clear   = ($urandom_range(0, 49) == 0);
            load_en = ($urandom_range(0, 11) == 0);
            start   = ($urandom_range(0, 4) == 0);
            mode    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 1) == 0) begin
                load_sec = 6'($urandom_range(55, 63));
                load_min = 6'($urandom_range(55, 63));
                load_hr  = 5'($urandom_range(20, 31));
            end else begin
                load_sec = 6'($urandom_range(0, 3));
                load_min = 6'($urandom_range(0, 1));
                load_hr  = 5'($urandom_range(0, 1));
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
